// File: rtl/sevenseg_scanner.sv
// Multiplexed seven-segment scanner: shadowed hex digits, per-digit mask,
// leading-zero blanking and PWM brightness, with fully registered outputs.
module sevenseg_scanner #(
  parameter int N_DIGITS = 8,
  parameter int TICK_DIV = 62500,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_mask,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [BRIGHT_W-1:0]   pwm_r;
  logic [4*N_DIGITS-1:0] shadow_value_r;
  logic [N_DIGITS-1:0]   shadow_dp_r;
  logic [6:0]            seg_r;
  logic                  dp_n_r;
  logic [N_DIGITS-1:0]   an_r;
  logic                  frame_done_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic [N_DIGITS:0]     zero_chain_s;
  logic [3:0]            nib_s;
  logic                  dp_sel_s;
  logic                  mask_sel_s;
  logic                  lz_sel_s;
  logic                  digit_on_s;
  logic [6:0]            seg_s;
  logic                  dp_n_s;
  logic [N_DIGITS-1:0]   an_s;

  assign tick_s = (cnt_r == CNT_LAST);
  assign wrap_s = tick_s && (idx_r == IDX_LAST);

  // Slot counter, digit index, free-running PWM and shadow registers; load beats tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r          <= {CNT_W{1'b0}};
      idx_r          <= {IDX_W{1'b0}};
      pwm_r          <= {BRIGHT_W{1'b0}};
      shadow_value_r <= {(4*N_DIGITS){1'b0}};
      shadow_dp_r    <= {N_DIGITS{1'b0}};
    end else begin
      pwm_r <= pwm_r + BRIGHT_W'(1'b1);
      if (load) begin
        shadow_value_r <= value;
        shadow_dp_r    <= dp;
        cnt_r          <= {CNT_W{1'b0}};
        idx_r          <= {IDX_W{1'b0}};
      end else if (tick_s) begin
        cnt_r <= {CNT_W{1'b0}};
        idx_r <= wrap_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end
  end

  // Select the current digit's nibble/dp/mask and its leading-zero status.
  always_comb begin
    logic hit;
    hit          = 1'b0;
    nib_s        = 4'h0;
    dp_sel_s     = 1'b0;
    mask_sel_s   = 1'b0;
    lz_sel_s     = 1'b0;
    zero_chain_s = {(N_DIGITS+1){1'b0}};
    // zero_chain_s[i] is set when nibbles i..N_DIGITS-1 are all zero.
    zero_chain_s[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_chain_s[i] = zero_chain_s[i+1] && (shadow_value_r[4*i +: 4] == 4'h0);
    end
    for (int i = 0; i < N_DIGITS; i++) begin
      hit        = (idx_r == IDX_W'(i));
      nib_s      = nib_s | ({4{hit}} & shadow_value_r[4*i +: 4]);
      dp_sel_s   = dp_sel_s   | (hit & shadow_dp_r[i]);
      mask_sel_s = mask_sel_s | (hit & digit_mask[i]);
      lz_sel_s   = lz_sel_s   | (hit & (i != 0) & zero_chain_s[i]);
    end
  end

  // Drive pattern for the selected digit, or blank when it is off.
  always_comb begin
    digit_on_s = (pwm_r <= brightness) && !mask_sel_s && !(lz_blank && lz_sel_s);
    if (digit_on_s) begin
      an_s   = ~(N_DIGITS'(1'b1) << idx_r);
      seg_s  = decode_hex(nib_s);
      dp_n_s = ~dp_sel_s;
    end else begin
      an_s   = {N_DIGITS{1'b1}};
      seg_s  = 7'h7F;
      dp_n_s = 1'b1;
    end
  end

  // Output registers: one clock behind the scan state, blank during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r         <= {N_DIGITS{1'b1}};
      seg_r        <= 7'h7F;
      dp_n_r       <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_s;
      seg_r        <= seg_s;
      dp_n_r       <= dp_n_s;
      frame_done_r <= wrap_s && !load;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp_n       = dp_n_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Self-checking bench for sevenseg_scanner: time-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sevenseg_scanner;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value;
  logic [3:0]    dp;
  logic [3:0]    digit_mask;
  logic          load;
  logic [BW-1:0] brightness;
  logic          lz_blank;
  logic [6:0]    seg;
  logic          dp_n;
  logic [3:0]    an;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  sevenseg_scanner #(.N_DIGITS(N), .TICK_DIV(TD), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .digit_mask(digit_mask),
    .load(load), .brightness(brightness), .lz_blank(lz_blank),
    .seg(seg), .dp_n(dp_n), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: m_t = cycles since last load/reset, m_p = cycles since reset.
  int          m_t = 0;
  int          m_p = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_dp  = 4'h0;
  int          e_idx;
  int          e_pw;
  logic        e_on;
  logic        e_lzb;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dpn;
  logic        e_fd;

  always @(posedge clk) begin
    e_idx = (m_t / TD) % N;
    e_pw  = m_p % (1 << BW);
    e_lzb = lz_blank && (e_idx > 0) && ((m_val >> (4 * e_idx)) == 16'h0);
    e_on  = !reset && (e_pw <= int'(brightness)) && !digit_mask[e_idx] && !e_lzb;
    if (e_on) begin
      e_an  = ~(4'b0001 << e_idx);
      e_seg = dec[(m_val >> (4 * e_idx)) & 16'hF];
      e_dpn = ~m_dp[e_idx];
    end else begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dpn = 1'b1;
    end
    e_fd = !reset && !load && ((m_t % (TD * N)) == (TD * N - 1));
    if (reset) begin
      m_t = 0; m_p = 0; m_val = 16'h0; m_dp = 4'h0;
    end else begin
      m_p = m_p + 1;
      if (load) begin
        m_t = 0; m_val = value; m_dp = dp;
      end else begin
        m_t = m_t + 1;
      end
    end
    #1;
    n_tests++;
    if ({an, seg, dp_n, frame_done} !== {e_an, e_seg, e_dpn, e_fd}) begin
      n_fail++;
      $display("FAIL model t=%0t: an=%b seg=%h dp_n=%b fd=%b, expected an=%b seg=%h dp_n=%b fd=%b",
               $time, an, seg, dp_n, frame_done, e_an, e_seg, e_dpn, e_fd);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
    value = 16'($urandom);
    dp    = 4'($urandom);
  endtask

  int          fd_cnt;
  int          low_cnt;
  logic        fd_last;
  logic [31:0] rv;
  int          keep;

  initial begin
    reset = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0;
    digit_mask = 4'h0; brightness = 2'd3; lz_blank = 1'b0;

    // Reset hold and release.
    repeat (3) step();
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    step();
    check("release_an", 32'(an), 32'hE);
    check("release_seg", 32'(seg), 32'h40);

    // Full scan of B3F0 with dp on digit 2; value/dp changes after load ignored.
    do_load(16'hB3F0, 4'b0100);
    fd_cnt = 0; fd_last = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (frame_done) fd_cnt++;
      fd_last = frame_done;
      if (k == 2)  begin check("scan_d0_seg", 32'(seg), 32'h40); check("scan_d0_dpn", 32'(dp_n), 32'h1); end
      if (k == 6)  check("scan_d1_seg", 32'(seg), 32'h0E);
      if (k == 10) begin
        check("scan_d2_seg", 32'(seg), 32'h30);
        check("scan_d2_an", 32'(an), 32'hB);
        check("scan_d2_dpn", 32'(dp_n), 32'h0);
      end
      if (k == 14) check("scan_d3_seg", 32'(seg), 32'h03);
    end
    check("scan_fd_count", 32'(fd_cnt), 32'd1);
    check("scan_fd_at_end", 32'(fd_last), 32'h1);

    // Brightness duty.
    brightness = 2'd1;
    do_load(16'h8888, 4'h0);
    low_cnt = 0;
    for (int k = 1; k <= 4; k++) begin step(); if (an != 4'hF) low_cnt++; end
    check("duty_b1", 32'(low_cnt), 32'd2);
    brightness = 2'd0;
    do_load(16'h8888, 4'h0);
    low_cnt = 0;
    for (int k = 1; k <= 4; k++) begin step(); if (an != 4'hF) low_cnt++; end
    check("duty_b0", 32'(low_cnt), 32'd1);
    brightness = 2'd3;

    // Leading-zero blanking.
    lz_blank = 1'b1;
    do_load(16'h0050, 4'h0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 2)  begin check("lz_d0_an", 32'(an), 32'hE); check("lz_d0_seg", 32'(seg), 32'h40); end
      if (k == 6)  begin check("lz_d1_an", 32'(an), 32'hD); check("lz_d1_seg", 32'(seg), 32'h12); end
      if (k == 10) check("lz_d2_an", 32'(an), 32'hF);
      if (k == 14) check("lz_d3_an", 32'(an), 32'hF);
    end
    do_load(16'h0000, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 2) begin check("lz0_d0_an", 32'(an), 32'hE); check("lz0_d0_dpn", 32'(dp_n), 32'h0); end
      if (k == 6) begin check("lz0_d1_an", 32'(an), 32'hF); check("lz0_d1_dpn", 32'(dp_n), 32'h1); end
    end
    lz_blank = 1'b0;

    // Load coincident with the wrapping tick.
    do_load(16'h1111, 4'h0);
    repeat (15) step();
    value = 16'h0007;
    load  = 1'b1;
    step();
    load  = 1'b0;
    check("ldtick_fd", 32'(frame_done), 32'h0);
    check("ldtick_old_an", 32'(an), 32'h7);
    step();
    check("ldtick_new_seg", 32'(seg), 32'h78);
    check("ldtick_new_an", 32'(an), 32'hE);

    // Reset mid-slot with digit 1 masked.
    digit_mask = 4'b0010;
    do_load(16'h1234, 4'h0);
    repeat (9) step();
    reset = 1'b1;
    step();
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    step();
    check("midrst_dpn", 32'(dp_n), 32'h1);
    reset = 1'b0;
    step();
    check("midrst_rel_an", 32'(an), 32'hE);
    repeat (5) step();
    check("midrst_mask_an", 32'(an), 32'hF);
    digit_mask = 4'h0;

    // Randomized traffic checked by the model.
    repeat (3000) begin
      reset      = ($urandom_range(0, 299) == 0);
      load       = ($urandom_range(0, 59) == 0);
      rv         = $urandom;
      keep       = $urandom_range(0, 4);
      value      = 16'(rv & ((32'd1 << (4 * keep)) - 32'd1));
      dp         = 4'($urandom);
      digit_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      brightness = BW'($urandom);
      lz_blank   = 1'($urandom);
      step();
    end
    reset = 1'b0; load = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
